// File: rtl/conv_lbx_sched.sv
// Line-buffer scheduler: tracks column/row position of the pixel stream, steers
// the K-1 line-buffer banks and flags when a full KxK window column is readable.
module conv_lbx_sched #(
  parameter int W_MAX = 1024,
  parameter int K     = 3,
  parameter int AW    = $clog2(W_MAX)
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          pixel_vld_i,
  input  logic          pixel_sof_i,
  input  logic          pixel_eol_i,
  output logic          mem_en_o,
  output logic [K-2:0]  mem_bank_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          win_vld_o,
  output logic          win_first_col_o,
  output logic          win_last_col_o,
  output logic [AW:0]   width_o,
  output logic          err_width_o
);
  localparam int RW = (K > 2) ? $clog2(K) : 1;
  localparam logic [AW-1:0] COL_MAX  = AW'(W_MAX - 1);
  localparam logic [RW-1:0] ROWS_MAX = RW'(K - 1);
  localparam logic [K-2:0]  BANK0    = (K-1)'(1);

  logic [AW-1:0] col_q, col_d, col_eff;
  logic [K-2:0]  bank_q, bank_d, bank_eff, bank_rot;
  logic [RW-1:0] rows_q, rows_d, rows_eff;
  logic [AW:0]   width_q, width_d, width_eff, col_len;
  logic          err_q, err_d, err_eff;
  logic          win_vld_q, win_vld_d;
  logic          win_first_q, win_first_d;
  logic          win_last_q, win_last_d;
  logic          sof, eol;

  // A sof pixel restarts the frame in the same cycle it is accepted.
  always_comb begin
    sof       = pixel_vld_i & pixel_sof_i;
    eol       = pixel_vld_i & pixel_eol_i;
    col_eff   = sof ? '0 : col_q;
    bank_eff  = sof ? BANK0 : bank_q;
    rows_eff  = sof ? '0 : rows_q;
    width_eff = sof ? '0 : width_q;
    err_eff   = sof ? 1'b0 : err_q;
    col_len   = {1'b0, col_eff} + 1'b1;
    bank_rot  = '0;
    for (int i = 0; i < K-1; i++) bank_rot[(i+1) % (K-1)] = bank_eff[i];
  end

  always_comb begin
    col_d       = col_q;
    bank_d      = bank_q;
    rows_d      = rows_q;
    width_d     = width_q;
    err_d       = err_q;
    win_vld_d   = 1'b0;
    win_first_d = 1'b0;
    win_last_d  = 1'b0;
    if (pixel_vld_i) begin
      bank_d      = bank_eff;
      rows_d      = rows_eff;
      width_d     = width_eff;
      err_d       = err_eff;
      win_vld_d   = (rows_eff == ROWS_MAX);
      win_first_d = win_vld_d & (col_eff == '0);
      win_last_d  = win_vld_d & pixel_eol_i;
      if (eol) begin
        col_d  = '0;
        bank_d = bank_rot;
        rows_d = (rows_eff == ROWS_MAX) ? ROWS_MAX : rows_eff + 1'b1;
        if (width_eff == '0)          width_d = col_len;
        else if (col_len != width_eff) err_d  = 1'b1;
      end else if (col_eff == COL_MAX) begin
        // Line longer than the buffer: park on the last address and flag it.
        col_d = col_eff;
        err_d = 1'b1;
      end else begin
        col_d = col_eff + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      col_q       <= '0;
      bank_q      <= BANK0;
      rows_q      <= '0;
      width_q     <= '0;
      err_q       <= 1'b0;
      win_vld_q   <= 1'b0;
      win_first_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      bank_q      <= bank_d;
      rows_q      <= rows_d;
      width_q     <= width_d;
      err_q       <= err_d;
      win_vld_q   <= win_vld_d;
      win_first_q <= win_first_d;
      win_last_q  <= win_last_d;
    end
  end

  assign mem_en_o        = pixel_vld_i;
  assign mem_addr_o      = col_eff;
  assign mem_bank_o      = bank_eff;
  assign win_vld_o       = win_vld_q;
  assign win_first_col_o = win_first_q;
  assign win_last_col_o  = win_last_q;
  assign width_o         = width_q;
  assign err_width_o     = err_q;
endmodule

// File: tb/tb_conv_lbx_sched.sv
// Randomized bench for conv_lbx_sched (W_MAX=8, K=3) against a frame/line level
// model: column counter, completed-line count, learned width and error flag.
module tb_conv_lbx_sched;
  localparam int W_MAX = 8;
  localparam int K     = 3;
  localparam int AW    = $clog2(W_MAX);

  logic          clk = 1'b0;
  logic          srst, pixel_vld_i, pixel_sof_i, pixel_eol_i;
  logic          mem_en_o, win_vld_o, win_first_col_o, win_last_col_o, err_width_o;
  logic [K-2:0]  mem_bank_o;
  logic [AW-1:0] mem_addr_o;
  logic [AW:0]   width_o;

  conv_lbx_sched #(.W_MAX(W_MAX), .K(K)) dut (
    .clk(clk), .srst(srst), .pixel_vld_i(pixel_vld_i), .pixel_sof_i(pixel_sof_i),
    .pixel_eol_i(pixel_eol_i), .mem_en_o(mem_en_o), .mem_bank_o(mem_bank_o),
    .mem_addr_o(mem_addr_o), .win_vld_o(win_vld_o), .win_first_col_o(win_first_col_o),
    .win_last_col_o(win_last_col_o), .width_o(width_o), .err_width_o(err_width_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  // model: pos = current column, lines = completed lines in frame
  int pos, lines, m_width, m_err, e_win, e_first, e_last;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pos = 0; lines = 0; m_width = 0; m_err = 0;
    e_win = 0; e_first = 0; e_last = 0;
  endtask

  // One clock: drive inputs, check at negedge, advance the model.
  task automatic step(input bit rst, input bit vld, input bit sof, input bit eol);
    srst = rst; pixel_vld_i = vld; pixel_sof_i = sof; pixel_eol_i = eol;
    @(negedge clk);
    chk("win_vld", win_vld_o, e_win);
    chk("win_first", win_first_col_o, e_first);
    chk("win_last", win_last_col_o, e_last);
    chk("width", width_o, m_width);
    chk("err", err_width_o, m_err);
    if (rst) model_reset();
    else begin
      chk("mem_en", mem_en_o, vld);
      if (vld) begin
        if (sof) begin pos = 0; lines = 0; m_width = 0; m_err = 0; end
        chk("mem_addr", mem_addr_o, pos);
        chk("mem_bank", mem_bank_o, 1 << (lines % (K-1)));
        e_win   = (lines >= K-1);
        e_first = e_win && (pos == 0);
        e_last  = e_win && eol;
        if (eol) begin
          if (m_width == 0) m_width = pos + 1;
          else if (pos + 1 != m_width) m_err = 1;
          pos = 0;
          lines++;
        end else if (pos == W_MAX-1) m_err = 1;
        else pos++;
      end else begin
        e_win = 0; e_first = 0; e_last = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic pix(input bit sof, input bit eol, input bit gap);
    step(0, 1, sof, eol);
    if (gap) step(0, 0, 0, 0);
  endtask

  task automatic line(input int w, input bit sof, input bit gap);
    for (int i = 0; i < w; i++) pix(sof && i == 0, i == w-1, gap);
  endtask

  initial begin
    int tgt;
    model_reset();
    srst = 1; pixel_vld_i = 0; pixel_sof_i = 0; pixel_eol_i = 0;
    @(posedge clk); #1;
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_width", width_o, 0);
    chk("rst_err", err_width_o, 0);
    chk("rst_win", win_vld_o, 0);

    // three width-4 lines, then extra idle to observe last window
    line(4, 1, 0); line(4, 0, 0); line(4, 0, 0);
    step(0, 0, 0, 0);
    // width mismatch, then sof clears error
    line(4, 1, 0); line(3, 0, 0); line(4, 0, 0); line(4, 1, 0);
    // overflow: 10 pixels without eol then eol
    pix(1, 0, 0);
    for (int i = 0; i < 9; i++) pix(0, 0, 0);
    pix(0, 1, 0);
    // gaps between every pixel
    line(4, 1, 1); line(4, 0, 1); line(4, 0, 1);
    // sof mid-frame at column 2 of line 3
    line(4, 1, 0); line(4, 0, 0); pix(0, 0, 0); pix(0, 0, 0);
    line(4, 1, 0); line(4, 0, 0); line(4, 0, 0);
    // reset mid-line then pixels without sof
    line(4, 1, 0); pix(0, 0, 0); pix(0, 0, 0); pix(0, 0, 0);
    step(1, 0, 0, 0);
    line(4, 0, 0); line(4, 0, 0); line(4, 0, 0);

    // randomized frames
    tgt = 4;
    for (int n = 0; n < 4000; n++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 5) step(1, 0, 0, 0);
      else if (r < 250) step(0, 0, 0, 0);
      else begin
        bit sof, eol;
        sof = ($urandom_range(0, 99) < 3);
        if (sof) tgt = $urandom_range(1, W_MAX);
        eol = ((sof ? 0 : pos) + 1 >= tgt) || ($urandom_range(0, 99) < 3);
        step(0, 1, sof, eol);
        if (eol && $urandom_range(0, 9) == 0) tgt = $urandom_range(1, W_MAX + 2);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
